// File: rtl/cpu_pkg.sv
// Types and constants shared by the instruction-fetch front end.
package cpu_pkg;

    localparam logic [31:0] RESET_PC = 32'h00003000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        fetch_state_e state;
        logic         ibuf_full;
    } fetch_dbg_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus and decode-side handshake of the fetch unit.
// Handshakes: imem_req/imem_gnt and id_valid/id_ready each transfer on a cycle
// where both are high; a raised imem_req holds with a stable address until
// granted or flushed.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_gnt, imem_rvalid, imem_rdata, id_ready
    );
endinterface

// File: rtl/fetch_ibuf.sv
// Synchronous FIFO of fetched {pc, instr} entries; push and pop may coincide
// when full, and clear empties it at the edge.
module fetch_ibuf
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full    = (32'(count) == DEPTH);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{pc: RESET_PC, instr: 32'h0};
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues one outstanding imem request at a time,
// advances the PC on grant and buffers returned words for decode.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter int          IBUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  pc,
    output logic         pc_adv,
    input  logic         flush,
    fetch_unit_if.master bus,
    output fetch_dbg_t   dbg
);

    localparam int CW = $clog2(IBUF_DEPTH + 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_DROP = DROP;

    logic [1:0]    st_q;
    logic [1:0]    st_d;
    logic [31:0]   req_pc_q;
    logic [31:0]   occ;
    logic          req;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    fetch_entry_t  head;

    // Occupancy counts the in-flight word and credits a pop this cycle, so a
    // new request can go out back-to-back with the returning one.
    always_comb begin
        occ = 32'(count) + 32'(st_q == S_WAIT) - 32'(bus.id_valid & bus.id_ready);
        req = !reset && !flush && (occ < 32'(IBUF_DEPTH)) &&
              (st_q == S_IDLE || (st_q == S_WAIT && bus.imem_rvalid));
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = {pc[31:2], 2'b00};
    assign pc_adv        = req & bus.imem_gnt;

    assign push = (st_q == S_WAIT) & bus.imem_rvalid & ~flush;
    assign pop  = bus.id_valid & bus.id_ready & ~flush;

    always_comb begin
        st_d = st_q;
        case (st_q)
            S_IDLE: if (pc_adv) st_d = S_WAIT;
            S_WAIT: begin
                if (bus.imem_rvalid) st_d = pc_adv ? S_WAIT : S_IDLE;
                else if (flush)      st_d = S_DROP;
            end
            S_DROP: if (bus.imem_rvalid) st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q     <= S_IDLE;
            req_pc_q <= RESET_PC;
        end else begin
            st_q <= st_d;
            if (pc_adv) req_pc_q <= pc;
        end
    end

    fetch_ibuf #(
        .DEPTH    (IBUF_DEPTH),
        .RESET_PC (RESET_PC)
    ) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ('{pc: req_pc_q, instr: bus.imem_rdata}),
        .pop       (pop),
        .clear     (flush),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    assign bus.id_valid = ~empty;
    assign bus.id_instr = head.instr;
    assign bus.id_pc    = head.pc;

    assign dbg.state     = fetch_state_e'(st_q);
    assign dbg.ibuf_full = full;

endmodule
